ysyx_sq_drain: RTL and testbench
================================

# ysyx_sq_drain

Store-queue drain unit at the receiving end of the ROU→LSU store interface: accepts committed stores from the reorder unit, holds them in a small FIFO, and drains them one at a time to the data-memory write port with a valid/ready handshake. Sits inside the LSU between the ROU commit path and the dcache/bus write channel. Also provides an empty indication for fence draining and an optional load-address conflict check.

## Interface
- `XLEN`, `YSYX_XLEN` (32): data/address width.
- `SQ_SIZE`, 4: queue depth in entries; power of two, at least 2.

- Clock and reset: one clock; reset is synchronous and active-high.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rou_valid`  in  1  ROU presents a committed instruction.
- `rou_store`  in  1  the instruction is a store.
- `rou_alu`  in  5  store-size code; bits [1:0]: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `rou_sq_waddr`  in  XLEN  store byte address.
- `rou_sq_wdata`  in  XLEN  store data, right-aligned.
- `rou_pc`  in  XLEN  store PC, carried for debug and trace.
- `rou_sq_ready`  out  1  queue can accept a store this cycle.
- `mem_wvalid`  out  1  head entry is presented to memory.
- `mem_waddr`  out  XLEN  byte address of the head entry.
- `mem_wdata`  out  XLEN  lane-aligned write data.
- `mem_wstrb`  out  4  byte strobes.
- `mem_pc`  out  XLEN  PC of the head entry.
- `mem_wready`  in  1  memory accepts the head entry.
- `sq_empty`  out  1  no entries pending.
- `ld_raddr`  in  XLEN  load address to check (used only with the macro).
- `ld_conflict`  out  1  a pending store overlaps the load word.

## Operation
- Enqueue occurs when `rou_valid && rou_store && rou_sq_ready`.
  - When `rou_valid && !rou_store`, nothing is enqueued.
  - When `rou_valid && rou_store && !rou_sq_ready`, the ROU must hold; the unit never drops a store.
- Lane formatting is done at enqueue, with `sh = rou_sq_waddr[1:0]`:
  - Strobe: byte `4'b0001<<sh`; half `4'b0011<<sh`; word `4'b1111`.
  - Data: `rou_sq_wdata << (8*sh)`, truncated to XLEN.
  - Strobe bits shifted past lane 3 are dropped; the ROU guarantees aligned accesses.
- Each entry stores: valid, byte address, formatted data, strobe, pc.
- Storage is a circular FIFO:
  - `head` and `tail` pointers are `$clog2(SQ_SIZE)` bits wide and wrap modulo SQ_SIZE.
  - `count` is `$clog2(SQ_SIZE)+1` bits wide.
- Dequeue occurs when `mem_wvalid && mem_wready`: `head` advances and that entry's valid bit clears.
- `mem_*` outputs are driven from the head entry registers.
  - While `mem_wvalid` is high, `mem_*` stay stable until the handshake completes.
- `rou_sq_ready = (count != SQ_SIZE)`, derived from the registered count.
  - When the queue is full, a same-cycle dequeue does not open a slot; the slot opens the following cycle.
- `sq_empty = (count == 0)`.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- Reset state: `head = tail = count = 0`, all valid bits 0.
  - Output reset values: `mem_wvalid = 0`, `sq_empty = 1`, `rou_sq_ready = 1`, `ld_conflict = 0`, `mem_*` data = 0.
- Reset mid-drain discards all entries, including an un-acknowledged head.

## Timing
- Enqueue to memory: a store enqueued at cycle N into an empty queue gives `mem_wvalid = 1` at cycle N+1.
- Zero-cycle path through an empty queue is not provided.
- Throughput: one dequeue per cycle while `mem_wready` is held high.
- `sq_empty` rises the cycle after the last dequeue handshake.
- `ld_conflict` is combinational from `ld_raddr` and the entry registers.
  - The entry being dequeued in the current cycle still counts as a conflict.

## Configuration
- Macro: `YSYX_SQ_LD_CHECK_EN`.
- Defined: `ld_conflict = OR over valid entries of (entry.addr[XLEN-1:2] == ld_raddr[XLEN-1:2])`, so the LSU stalls loads until conflicting stores drain.
- Undefined: the comparators are not built, `ld_conflict` is tied to 0, and `ld_raddr` is unused; the LSU must then wait for `sq_empty` before issuing loads.

## Test plan
- After reset: `rou_sq_ready = 1`, `sq_empty = 1`, `mem_wvalid = 0`.
- sb with addr 0x8000_0003, data 0xAB: next cycle `mem_wvalid = 1`, `mem_waddr = 0x8000_0003`, `mem_wstrb = 4'b1000`, `mem_wdata = 0xAB00_0000`.
- Fill 4 stores with `mem_wready = 0`: `rou_sq_ready = 0` after the 4th.
  - A 5th store is held, not enqueued.
  - Pulse `mem_wready` once: `rou_sq_ready = 1` the next cycle; the drain order matches enqueue order.
- `mem_wready` held at 1 with back-to-back sw to 0x100, 0x104, 0x108: one handshake per cycle; `sq_empty = 1` one cycle after the last handshake.
- With `YSYX_SQ_LD_CHECK_EN`, sh pending at 0x206: `ld_raddr = 0x204` gives `ld_conflict = 1`; `ld_raddr = 0x208` gives 0; after the drain, 0x204 gives 0.
- Reset asserted while 3 entries are pending and `mem_wvalid = 1`: the next cycle `mem_wvalid = 0`, `sq_empty = 1`.

Source files
------------

// File: rtl/ysyx_sq_drain.sv
// ysyx_sq_drain: store-queue FIFO draining committed stores to the memory write port; YSYX_SQ_LD_CHECK_EN enables ld_conflict
module ysyx_sq_drain #(
  parameter int XLEN    = 32,
  parameter int SQ_SIZE = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rou_valid,
  input  logic            rou_store,
  input  logic [4:0]      rou_alu,
  input  logic [XLEN-1:0] rou_sq_waddr,
  input  logic [XLEN-1:0] rou_sq_wdata,
  input  logic [XLEN-1:0] rou_pc,
  output logic            rou_sq_ready,
  output logic            mem_wvalid,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_pc,
  input  logic            mem_wready,
  output logic            sq_empty,
  input  logic [XLEN-1:0] ld_raddr,
  output logic            ld_conflict
);
  localparam int AW = $clog2(SQ_SIZE);
  localparam logic [AW:0] FULL = (AW+1)'(SQ_SIZE);
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [SQ_SIZE-1:0] vld;
  logic [XLEN-1:0] addr_q [SQ_SIZE];
  logic [XLEN-1:0] data_q [SQ_SIZE];
  logic [XLEN-1:0] pc_q [SQ_SIZE];
  logic [3:0] strb_q [SQ_SIZE];
  logic [1:0] sh;
  logic [3:0] strb_in;
  logic enq, deq;
  logic unused_alu;
  assign unused_alu = ^rou_alu[4:2];
  assign sh = rou_sq_waddr[1:0];
  assign rou_sq_ready = count != FULL;
  assign sq_empty = count == '0;
  assign enq = rou_valid && rou_store && rou_sq_ready;
  assign deq = mem_wvalid && mem_wready;
  assign mem_wvalid = vld[head];
  assign mem_waddr = addr_q[head];
  assign mem_wdata = data_q[head];
  assign mem_wstrb = strb_q[head];
  assign mem_pc = pc_q[head];
  // lane strobe from size code; reserved code behaves as a word
  always_comb strb_in = rou_alu[1:0] == 2'b00 ? 4'b0001 << sh : rou_alu[1:0] == 2'b01 ? 4'b0011 << sh : 4'b1111;
  // circular FIFO: enqueue at tail, dequeue at head on handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      for (int i = 0; i < SQ_SIZE; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        pc_q[i]   <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        vld[tail]    <= 1'b1;
        addr_q[tail] <= rou_sq_waddr;
        data_q[tail] <= rou_sq_wdata << {sh, 3'b000};
        pc_q[tail]   <= rou_pc;
        strb_q[tail] <= strb_in;
        tail         <= tail + 1'b1;
      end
      if (deq) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
    end
  end
`ifdef YSYX_SQ_LD_CHECK_EN
  logic unused_ld;
  assign unused_ld = ^ld_raddr[1:0];
  // word-granular match of the load against every pending store
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < SQ_SIZE; i++) ld_conflict = ld_conflict | (vld[i] && addr_q[i][XLEN-1:2] == ld_raddr[XLEN-1:2]);
  end
`else
  logic unused_ld;
  assign unused_ld = ^ld_raddr;
  assign ld_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_sq_drain.sv
// tb_ysyx_sq_drain: randomized and directed checks of ysyx_sq_drain against a queue model
module tb_ysyx_sq_drain;
  localparam int SQ = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic rou_valid = 1'b0, rou_store = 1'b0, mem_wready = 1'b0;
  logic [4:0] rou_alu = '0;
  logic [31:0] rou_sq_waddr = '0, rou_sq_wdata = '0, rou_pc = '0, ld_raddr = '0;
  logic rou_sq_ready, mem_wvalid, sq_empty, ld_conflict;
  logic [31:0] mem_waddr, mem_wdata, mem_pc;
  logic [3:0] mem_wstrb;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [31:0] addr, data, pc; logic [3:0] strb;} ent_t;
  ent_t q[$];

  ysyx_sq_drain #(.XLEN(32), .SQ_SIZE(SQ)) dut (
    .clock(clock), .reset(reset), .rou_valid(rou_valid), .rou_store(rou_store),
    .rou_alu(rou_alu), .rou_sq_waddr(rou_sq_waddr), .rou_sq_wdata(rou_sq_wdata),
    .rou_pc(rou_pc), .rou_sq_ready(rou_sq_ready), .mem_wvalid(mem_wvalid),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_pc(mem_pc), .mem_wready(mem_wready), .sq_empty(sq_empty),
    .ld_raddr(ld_raddr), .ld_conflict(ld_conflict)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk();
    ent_t e;
    int s, nb;
    s = int'(rou_sq_waddr[1:0]);
    nb = rou_alu[1:0] == 2'd0 ? 1 : rou_alu[1:0] == 2'd1 ? 2 : 4;
    e.addr = rou_sq_waddr;
    e.pc = rou_pc;
    e.data = rou_sq_wdata << (8 * s);
    e.strb = nb == 4 ? 4'hF : 4'(((1 << nb) - 1) << s);
    return e;
  endfunction

  function automatic logic exp_conflict();
    logic c = 1'b0;
`ifdef YSYX_SQ_LD_CHECK_EN
    foreach (q[i]) if (q[i].addr[31:2] == ld_raddr[31:2]) c = 1'b1;
`endif
    return c;
  endfunction

  task automatic check_outputs();
    chk("ready", rou_sq_ready, q.size() != SQ);
    chk("empty", sq_empty, q.size() == 0);
    chk("wvalid", mem_wvalid, q.size() != 0);
    chk("conflict", ld_conflict, exp_conflict());
    if (q.size() != 0) begin
      chk("waddr", mem_waddr, q[0].addr);
      chk("wdata", mem_wdata, q[0].data);
      chk("wstrb", mem_wstrb, q[0].strb);
      chk("pc", mem_pc, q[0].pc);
    end
  endtask

  task automatic step();
    logic e, d;
    @(negedge clock);
    check_outputs();
    e = rou_valid && rou_store && q.size() != SQ;
    d = q.size() != 0 && mem_wready;
    if (reset) q.delete();
    else begin
      if (d) void'(q.pop_front());
      if (e) q.push_back(mk());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] d);
    rou_valid = 1'b1; rou_store = 1'b1; rou_alu = alu;
    rou_sq_waddr = a; rou_sq_wdata = d; rou_pc = $urandom;
  endtask

  task automatic idle();
    rou_valid = 1'b0; rou_store = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", rou_sq_ready, 1);
    chk("rst_empty", sq_empty, 1);
    chk("rst_wvalid", mem_wvalid, 0);
    chk("rst_wdata", mem_wdata, 0);
    put(5'd0, 32'h8000_0003, 32'h0000_00AB);
    step();
    idle();
    chk("sb_wvalid", mem_wvalid, 1);
    chk("sb_waddr", mem_waddr, 32'h8000_0003);
    chk("sb_wstrb", mem_wstrb, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hAB00_0000);
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      put(5'd2, 32'h40 + 32'(4 * i), $urandom);
      step();
    end
    chk("full_ready", rou_sq_ready, 0);
    put(5'd2, 32'h50, 32'h5555_5555);
    step();
    step();
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    chk("reopen_ready", rou_sq_ready, 1);
    step();
    idle();
    mem_wready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    put(5'd2, 32'h100, $urandom); step();
    put(5'd2, 32'h104, $urandom); step();
    put(5'd2, 32'h108, $urandom); step();
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("b2b_empty", sq_empty, 1);
    mem_wready = 1'b0;
    put(5'd1, 32'h206, 32'h0000_BEEF);
    step();
    idle();
    ld_raddr = 32'h204; step();
    ld_raddr = 32'h208; step();
    mem_wready = 1'b1; step(); step();
    ld_raddr = 32'h204; step();
    chk("drained_conflict", ld_conflict, 0);
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(5'(i), 32'h300 + 32'(4 * i), $urandom);
      step();
    end
    idle();
    chk("pre_rst_wvalid", mem_wvalid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_wvalid", mem_wvalid, 0);
    chk("mid_rst_empty", sq_empty, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      a[1:0] = sz == 2'd0 ? 2'($urandom) : sz == 2'd1 ? {1'($urandom), 1'b0} : 2'b00;
      rou_valid = $urandom_range(0, 3) != 0;
      rou_store = $urandom_range(0, 4) != 0;
      rou_alu = {3'($urandom), sz};
      rou_sq_waddr = a;
      rou_sq_wdata = $urandom;
      rou_pc = $urandom;
      mem_wready = $urandom_range(0, 2) != 0;
      ld_raddr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
